// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and helpers for the PLL lock sequencer.
// The state encoding is fixed at 3 bits so that debug taps and checkers see stable values.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // Largest of three cycle counts; sizes the shared state timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level.
// Both flops reset to 0, so a missing PLL reads as "not locked" during and after reset.
module sync_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops on the reference clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: pulses PLL RESETB, waits for LOCK with timeout/retry, requires LOCK to be
// stable before releasing the downstream reset, and pulls that reset back on any lock loss.
// Runs entirely on the reference clock; the PLL output clock is never used.
// Optional feature macro: LOCK_LOSS_COUNTER_EN (saturating count of lock losses while in RUN).
// restart is a single-cycle pulse sampled on the clock; it overrides every other transition.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 12000,
  parameter int STABLE_CYCLES = 1200,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             locked,
  input  logic             restart,
  output logic             pll_resetb,
  output logic             sys_reset_n,
  output logic             ready,
  output logic             fault,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output state_t           state_dbg
);

  localparam int TIMER_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int TW        = $clog2(TIMER_MAX + 1);
  localparam int RW        = $clog2(MAX_RETRIES + 1);

  state_t          state;
  state_t          next_state;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   retries;
  logic            locked_s;
  logic            rst_done;
  logic            lock_timeout;
  logic            stable_done;
  logic            last_retry;
  logic            pll_resetb_d;
  logic            run_d;
  logic            fault_d;

  sync_2ff u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (locked),
    .q       (locked_s)
  );

  // The timer restarts at 0 on every state change, so each terminal count is "value minus one".
  assign rst_done     = (timer == TW'(RST_CYCLES - 1));
  assign lock_timeout = (timer == TW'(LOCK_TIMEOUT - 1));
  assign stable_done  = (timer == TW'(STABLE_CYCLES - 1));
  assign last_retry   = (retries == RW'(MAX_RETRIES - 1));
  assign state_dbg    = state;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= PLL_RST;
    else          state <= next_state;
  end

  // Next-state decode; restart wins over everything else.
  always_comb begin
    next_state = state;
    if (restart) begin
      next_state = PLL_RST;
    end else begin
      unique case (state)
        PLL_RST:   if (rst_done) next_state = WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked_s)          next_state = STABLE;
          else if (lock_timeout) next_state = last_retry ? FAULT : PLL_RST;
        end
        STABLE: begin
          if (!locked_s)        next_state = WAIT_LOCK;
          else if (stable_done) next_state = RUN;
        end
        RUN:       if (!locked_s) next_state = PLL_RST;
        FAULT:     next_state = FAULT;
        default:   next_state = PLL_RST;
      endcase
    end
  end

  // Output decode from the next state, so registered outputs change on the same edge as the state.
  always_comb begin
    pll_resetb_d = (next_state == WAIT_LOCK) || (next_state == STABLE) || (next_state == RUN);
    run_d        = (next_state == RUN);
    fault_d      = (next_state == FAULT);
  end

  // Output registers; ready and sys_reset_n share one decode so they can never disagree.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pll_resetb  <= 1'b0;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      pll_resetb  <= pll_resetb_d;
      sys_reset_n <= run_d;
      ready       <= run_d;
      fault       <= fault_d;
    end
  end

  // State timer: cleared on any state change or restart; frozen in RUN/FAULT so it cannot wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (restart || (next_state != state)) begin
      timer <= '0;
    end else if ((state == PLL_RST) || (state == WAIT_LOCK) || (state == STABLE)) begin
      timer <= timer + 1'b1;
    end
  end

  // Retry counter: one per lock timeout, cleared by restart or on reaching RUN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retries <= '0;
    end else if (restart) begin
      retries <= '0;
    end else if ((next_state == RUN) && (state != RUN)) begin
      retries <= '0;
    end else if ((state == WAIT_LOCK) && !locked_s && lock_timeout) begin
      retries <= retries + 1'b1;
    end
  end

`ifdef LOCK_LOSS_COUNTER_EN
  logic [CNT_W-1:0] loss_cnt;

  // Count lock losses seen in RUN (even if restart coincides); saturate, clear only on reset_n.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      loss_cnt <= '0;
    end else if ((state == RUN) && !locked_s && (loss_cnt != {CNT_W{1'b1}})) begin
      loss_cnt <= loss_cnt + 1'b1;
    end
  end

  assign lock_loss_cnt = loss_cnt;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule
